// File: rtl/vdp_sprite_meta_dma.sv
// Sprite attribute table copy engine for the sprite core metadata blocks.
// Copies a packed table (two VRAM words per sprite) into the x/y/g metadata
// blocks and shares the single metadata write port with direct host writes.
// Optional build macro: SPRITE_DMA_VBLANK_GATE_EN holds metadata writes
// until vblank is high; VRAM reads are never gated.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; host owns the metadata write port
// RD0    | requesting word0 (x/y values) of the current sprite
// WX     | issuing the x-block write
// WY     | issuing the y-block write, then requesting word1
// RD1    | requesting word1 (g value) of the current sprite
// WG     | issuing the g-block write, advance to next sprite or finish
// DONE   | one-cycle completion pulse, then back to IDLE

module vdp_sprite_meta_dma #(
  parameter int VRAM_AW = 14,
  parameter int META_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VRAM_AW-1:0] table_base,
  input  logic [META_AW-1:0] first_sprite,
  input  logic [META_AW-1:0] sprite_count,
  input  logic               vblank,
  output logic               busy,
  output logic               done,
  output logic               vram_read_req,
  output logic [VRAM_AW-1:0] vram_read_address,
  input  logic [31:0]        vram_read_data,
  input  logic               vram_data_valid,
  input  logic [META_AW-1:0] host_meta_address,
  input  logic [15:0]        host_meta_write_data,
  input  logic [2:0]         host_meta_block_select,
  input  logic               host_meta_we,
  output logic               host_ready,
  output logic [META_AW-1:0] meta_address,
  output logic [15:0]        meta_write_data,
  output logic [2:0]         meta_block_select,
  output logic               meta_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_WX,
    S_WY,
    S_RD1,
    S_WG,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        read_word;
  logic [META_AW-1:0] meta_index;
  // Sprites still to copy; a loaded 0 wraps through 255..1, giving 256.
  logic [META_AW-1:0] remaining;
  logic               write_ok;

`ifdef SPRITE_DMA_VBLANK_GATE_EN
  assign write_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign write_ok      = 1'b1;
`endif

  // Copy sequencer, host write pass-through and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      host_ready        <= 1'b1;
      vram_read_req     <= 1'b0;
      vram_read_address <= '0;
      read_word         <= '0;
      meta_index        <= '0;
      remaining         <= '0;
      meta_address      <= '0;
      meta_write_data   <= '0;
      meta_block_select <= '0;
      meta_we           <= 1'b0;
    end else begin
      meta_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // host_ready is high throughout IDLE, so a strobe here is accepted.
          if (host_meta_we) begin
            meta_address      <= host_meta_address;
            meta_write_data   <= host_meta_write_data;
            meta_block_select <= host_meta_block_select;
            meta_we           <= 1'b1;
          end
          if (start) begin
            vram_read_address <= table_base;
            meta_index        <= first_sprite;
            remaining         <= sprite_count;
            busy              <= 1'b1;
            host_ready        <= 1'b0;
            vram_read_req     <= 1'b1;
            state             <= S_RD0;
          end
        end
        S_RD0: begin
          if (vram_data_valid) begin
            read_word     <= vram_read_data;
            vram_read_req <= 1'b0;
            state         <= S_WX;
          end
        end
        S_WX: begin
          if (write_ok) begin
            meta_address      <= meta_index;
            meta_write_data   <= read_word[15:0];
            meta_block_select <= 3'b001;
            meta_we           <= 1'b1;
            state             <= S_WY;
          end
        end
        S_WY: begin
          if (write_ok) begin
            meta_address      <= meta_index;
            meta_write_data   <= read_word[31:16];
            meta_block_select <= 3'b010;
            meta_we           <= 1'b1;
            vram_read_address <= vram_read_address + VRAM_AW'(1);
            vram_read_req     <= 1'b1;
            state             <= S_RD1;
          end
        end
        S_RD1: begin
          if (vram_data_valid) begin
            read_word     <= vram_read_data;
            vram_read_req <= 1'b0;
            state         <= S_WG;
          end
        end
        S_WG: begin
          if (write_ok) begin
            meta_address      <= meta_index;
            meta_write_data   <= read_word[15:0];
            meta_block_select <= 3'b100;
            meta_we           <= 1'b1;
            meta_index        <= meta_index + META_AW'(1);
            remaining         <= remaining - META_AW'(1);
            vram_read_address <= vram_read_address + VRAM_AW'(1);
            if (remaining == META_AW'(1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              vram_read_req <= 1'b1;
              state         <= S_RD0;
            end
          end
        end
        S_DONE: begin
          busy       <= 1'b0;
          host_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vdp_sprite_meta_dma.md
Name: vdp_sprite_meta_dma

Overview:
- Controller that sequences writes into the sprite core's x/y/g metadata blocks.
- Copies a packed sprite attribute table from VRAM into metadata RAM on a start pulse.
- Arbitrates the single metadata write port between this copy engine and direct host register writes.
- Sits between the host register interface, the VRAM read arbiter, and the sprite core's meta_* inputs.

Parameters:
- VRAM_AW, 14, VRAM word (32-bit) address width.
- META_AW, 8, metadata index width (256 sprites).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a table copy when idle
- table_base  in  VRAM_AW  VRAM word address of sprite 0's entry
- first_sprite  in  META_AW  destination metadata index of the first copied sprite
- sprite_count  in  META_AW  number of sprites to copy; 0 means 256
- vblank  in  1  vertical blank flag (used only with the optional feature)
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse when a copy completes
- vram_read_req  out  1  VRAM read request, held until data valid
- vram_read_address  out  VRAM_AW  VRAM read address
- vram_read_data  in  32  VRAM read data
- vram_data_valid  in  1  read data valid for the current request
- host_meta_address  in  META_AW  host write index
- host_meta_write_data  in  16  host write data
- host_meta_block_select  in  3  host block select (bit0 x, bit1 y, bit2 g)
- host_meta_we  in  1  host write strobe
- host_ready  out  1  host write accepted this cycle
- meta_address  out  META_AW  to sprite core
- meta_write_data  out  16  to sprite core
- meta_block_select  out  3  to sprite core
- meta_we  out  1  to sprite core

Behaviour:
- Reset values: all outputs 0, except host_ready, which is 1. FSM enters IDLE.
- Table entry per sprite, two VRAM words:
  - word0[15:0] = x_block value; word0[31:16] = y_block value.
  - word1[15:0] = g_block value; word1[31:16] ignored.
- Addressing:
  - Word address = table_base + 2*i + k, where k = 0/1. Sum truncated to VRAM_AW, so it wraps.
  - meta_address = first_sprite + i, truncated to META_AW, so it wraps.
- Parameter capture: on start in IDLE, latch table_base, first_sprite and sprite_count, and set i = 0. Later changes to these inputs are ignored until the next start.
- FSM states:
  - IDLE: busy = 0, host_ready = 1. start -> RD0.
  - RD0: vram_read_req = 1 with word0 address. On vram_data_valid, capture data -> WX.
  - WX: write x value to block select 3'b001 -> WY.
  - WY: write y value to block select 3'b010 -> RD1.
  - RD1: request word1. On valid, capture data -> WG.
  - WG: write g value to block select 3'b100. Then i += 1; if i == count -> DONE, else -> RD0.
  - DONE: done = 1 for one cycle -> IDLE.
- VRAM handshake: request and address stay stable until vram_data_valid; data is sampled in the valid cycle. Read latency is arbitrary (at least 1 cycle). A valid seen with no request outstanding is ignored.
- meta_* outputs are registered. A write is presented for exactly one cycle, in the cycle after the WX/WY/WG state is entered, so each write completes in a single cycle. meta_we is 0 in every other cycle.
- busy = 1 from the cycle after start through the DONE cycle inclusive.
- Host path:
  - When host_ready = 1 and host_meta_we = 1, the host fields appear on meta_* one cycle later with meta_we = 1.
  - While busy, host_ready = 0 and host writes are dropped. The host must hold its write until host_ready = 1.
- Simultaneous events:
  - start and host write in the same IDLE cycle: the host write is issued; DMA enters RD0 next cycle.
  - start while busy is ignored.
- sprite_count = 0 copies 256 sprites (the counter compares on wrap).
- Per-sprite cost with 1-cycle VRAM latency: 7 cycles (RD0 2, WX 1, WY 1, RD1 2, WG 1).
- Reset mid-copy: return to IDLE in the next cycle. No further meta_we or vram_read_req is issued and done is not pulsed. Partially written metadata is left as is.

Optional Feature:
- SPRITE_DMA_VBLANK_GATE_EN:
  - Defined: the FSM holds in WX/WY/WG and suppresses meta_we while vblank = 0. The pending write issues in the first cycle with vblank = 1. VRAM reads are unaffected.
  - Undefined: the vblank port is ignored and writes are never stalled.

Test Plan:
- Copy 1 sprite: table_base = 0x0100, first_sprite = 5, count = 1, word0 = 0x0412_0033, word1 = 0x0000_F2AB, 1-cycle latency -> meta writes [5] x = 0x0033 (sel 001), y = 0x0412 (sel 010), g = 0xF2AB (sel 100); VRAM addresses 0x0100 then 0x0101; done pulses once; busy for 8 cycles.
- Wrap: table_base = 0x3FFF, first_sprite = 0xFF, count = 2 -> VRAM addresses 0x3FFF, 0x0000, 0x0001, 0x0002; meta indices 0xFF then 0x00.
- count = 0 -> exactly 256 sprites × 3 writes = 768 meta_we pulses, then one done.
- Variable latency: vram_data_valid delayed 0–5 random cycles -> address stable while req is high; data order and values correct.
- Arbitration: host write during busy -> host_ready = 0 and no meta_we from the host. Held write issues the cycle after return to IDLE. Start while busy -> no restart.
- Reset asserted mid-WY -> next cycle meta_we = 0, vram_read_req = 0, busy = 0, host_ready = 1; no done. With SPRITE_DMA_VBLANK_GATE_EN, vblank = 0 stalls in WX until vblank rises.
